// File: rtl/seq_shifter_pkg.sv
// Shared types and widths for the iterative shifter: op encoding, FSM states,
// and the one-hot check applied to the incoming op flags.
package seq_shifter_pkg;

  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR} shift_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  function automatic logic op_onehot(input logic lsl, input logic lsr, input logic asr);
    return ({lsl, lsr, asr} == 3'b100) || ({lsl, lsr, asr} == 3'b010) ||
           ({lsl, lsr, asr} == 3'b001);
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle between the ALU and the iterative shifter.
// The ALU drives the request side (master); the shifter answers (slave).
interface seq_shifter_if;
  import seq_shifter_pkg::*;

  logic               start;
  logic               is_lsl;
  logic               is_lsr;
  logic               is_asr;
  logic [WORD_W-1:0]  m;
  logic [SHAMT_W-1:0] n;
  logic               busy;
  logic               done;
  logic               err;
  logic [WORD_W-1:0]  aluResult;

  modport master (
    output start, is_lsl, is_lsr, is_asr, m, n,
    input  busy, done, err, aluResult
  );

  modport slave (
    input  start, is_lsl, is_lsr, is_asr, m, n,
    output busy, done, err, aluResult
  );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// One shift step of up to STEP bits: combinational, zero latency.
// ASR fill comes from i_sign (the original operand's bit 31), not the working word.
module shift_step
  import seq_shifter_pkg::*;
(
  input  logic [WORD_W-1:0]  i_data,
  input  shift_op_t          i_op,
  input  logic               i_sign,
  input  logic [SHAMT_W-1:0] i_k,
  output logic [WORD_W-1:0]  o_data
);

  logic [WORD_W-1:0] w_fill;

  always_comb begin
    w_fill = '0;
    o_data = i_data;
    case (i_op)
      SH_LSL: o_data = i_data << i_k;
      SH_LSR: o_data = i_data >> i_k;
      SH_ASR: begin
        w_fill = i_sign ? ~({WORD_W{1'b1}} >> i_k) : '0;
        o_data = (i_data >> i_k) | w_fill;
      end
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative LSL/LSR/ASR unit; done arrives 1+ceil(n/STEP) cycles after accept.
// Starts are accepted only in IDLE; anything presented while busy or in DONE is dropped.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int STEP = 1
) (
  input logic         clk,
  input logic         reset,
  seq_shifter_if.slave bus
);

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_t             r_state;
  logic [WORD_W-1:0]  r_data;
  shift_op_t          r_op;
  logic               r_sign;
  logic [SHAMT_W-1:0] r_rem;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [WORD_W-1:0]  r_result;

  logic               w_onehot;
  shift_op_t          w_op;
  logic [SHAMT_W-1:0] w_k;
  logic [WORD_W-1:0]  w_shifted;

  assign w_onehot = op_onehot(bus.is_lsl, bus.is_lsr, bus.is_asr);
  assign w_op     = bus.is_lsl ? SH_LSL : (bus.is_lsr ? SH_LSR : SH_ASR);
  assign w_k      = (r_rem < STEP_K) ? r_rem : STEP_K;

  shift_step u_step (
    .i_data (r_data),
    .i_op   (r_op),
    .i_sign (r_sign),
    .i_k    (w_k),
    .o_data (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_op     <= SH_LSL;
      r_sign   <= 1'b0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (bus.start) begin
            r_data <= bus.m;
            r_sign <= bus.m[WORD_W-1];
            r_op   <= w_op;
            r_rem  <= bus.n;
            // Zero shift and malformed ops skip straight to DONE with the operand.
            if (bus.n == '0 || !w_onehot) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_err    <= !w_onehot;
              r_result <= bus.m;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_result <= w_shifted;
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.aluResult = r_result;

endmodule
